// File: rtl/bcd_rate_counter.sv
// BCD up/down counter advanced by a DIV-cycle prescaler, with load, wrap pulse and 7-seg decode.
// Down counting (borrow chain) exists only when BCD_RATE_COUNTER_DOWN_EN is defined.

module bcd_rate_counter_digit (
  input  logic [3:0] dig_i,
  input  logic [3:0] ld_i,
  input  logic       step_i,
  input  logic       up_i,
  output logic [3:0] nxt_o,
  output logic [3:0] ld_clamp_o,
  output logic       cout_o,
  output logic [6:0] seg_o
);

`ifndef BCD_RATE_COUNTER_DOWN_EN
  logic unused_up;
  assign unused_up = up_i;
`endif

  always_comb begin
    nxt_o  = dig_i;
    cout_o = 1'b0;
    if (step_i) begin
`ifdef BCD_RATE_COUNTER_DOWN_EN
      if (!up_i) begin
        if (dig_i == 4'd0) begin
          nxt_o  = 4'd9;
          cout_o = 1'b1;
        end else begin
          nxt_o = dig_i - 4'd1;
        end
      end else if (dig_i >= 4'd9) begin
        nxt_o  = 4'd0;
        cout_o = 1'b1;
      end else begin
        nxt_o = dig_i + 4'd1;
      end
`else
      if (dig_i >= 4'd9) begin
        nxt_o  = 4'd0;
        cout_o = 1'b1;
      end else begin
        nxt_o = dig_i + 4'd1;
      end
`endif
    end
  end

  assign ld_clamp_o = (ld_i > 4'd9) ? 4'd9 : ld_i;

  // Segments a..g on bits 0..6, low = lit.
  always_comb begin
    case (dig_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

module bcd_rate_counter #(
  parameter int DIGITS = 2,
  parameter int DIV    = 50000000
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0]          presc_q, presc_d;
  logic [4*DIGITS-1:0]    count_q, count_d;
  logic                   wrap_q, wrap_d;

  logic [4*DIGITS-1:0]    step_val;
  logic [4*DIGITS-1:0]    ld_clamp;
  logic [DIGITS:0]        carry;

  assign tick     = en && (presc_q == PMAX);
  assign carry[0] = tick;

  // Carry/borrow ripples digit to digit; carry out of the top digit is the rollover.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      bcd_rate_counter_digit u_dig (
        .dig_i      (count_q[4*gi +: 4]),
        .ld_i       (load_val[4*gi +: 4]),
        .step_i     (carry[gi]),
        .up_i       (up_dn),
        .nxt_o      (step_val[4*gi +: 4]),
        .ld_clamp_o (ld_clamp[4*gi +: 4]),
        .cout_o     (carry[gi+1]),
        .seg_o      (hex[7*gi +: 7])
      );
    end
  endgenerate

  always_comb begin
    presc_d = presc_q;
    count_d = step_val;
    wrap_d  = 1'b0;
    if (load) begin
      presc_d = '0;
      count_d = ld_clamp;
    end else begin
      wrap_d = carry[DIGITS];
      if (en) presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_rate_counter.sv
// Directed bench: 2-digit DIV=4 counter plus a 1-digit DIV=1 counter sharing clk/clear.
module tb_bcd_rate_counter;

  logic        clk = 1'b0;
  logic        clear, en, load, up_dn;
  logic [7:0]  load_val;
  logic [7:0]  count_a;
  logic        tick_a, wrap_a;
  logic [13:0] hex_a;

  logic        load_b;
  logic [3:0]  load_val_b, count_b;
  logic        tick_b, wrap_b;
  logic [6:0]  hex_b;

  int n_vec = 0;
  int n_err = 0;
  int g;

  bcd_rate_counter #(.DIGITS(2), .DIV(4)) dut_a (
    .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(count_a), .tick(tick_a), .wrap(wrap_a), .hex(hex_a)
  );

  bcd_rate_counter #(.DIGITS(1), .DIV(1)) dut_b (
    .clk(clk), .clear(clear), .en(1'b1), .load(load_b), .load_val(load_val_b),
    .up_dn(1'b0), .count(count_b), .tick(tick_b), .wrap(wrap_b), .hex(hex_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_tick(output int gap);
    gap = 0;
    do begin
      step();
      gap++;
    end while (!tick_a && gap < 20);
    if (!tick_a) check("tick_timeout", 32'(tick_a), 32'd1);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    clear = 1'b0; en = 1'b1; load = 1'b0; load_val = 8'h00; up_dn = 1'b1;
    load_b = 1'b0; load_val_b = 4'h0;
    #3;
    check("rst_count", 32'(count_a), 32'h00);
    check("rst_hex", 32'(hex_a), 32'h2040);
    check("rst_wrap", 32'(wrap_a), 32'd0);
    check("rst_tick", 32'(tick_a), 32'd0);
    check("rst_count_b", 32'(count_b), 32'h0);
    check("rst_hex_b", 32'(hex_b), 32'h40);
    step();
    check("rst_hold", 32'(count_a), 32'h00);
    #3 clear = 1'b1;

    // Up count 00 -> 10, one tick every 4 cycles
    for (int k = 1; k <= 10; k++) begin
      next_tick(g);
      check("tick_gap", 32'(g), 32'd3);
      step();
      check("up_count", 32'(count_a), 32'((k / 10) * 16 + (k % 10)));
      check("up_nowrap", 32'(wrap_a), 32'd0);
    end

    // 99 -> 00 with single-cycle wrap
    do_load(8'h99);
    check("load99", 32'(count_a), 32'h99);
    check("load_presc", 32'(dut_a.presc_q), 32'd0);
    next_tick(g);
    check("load_gap", 32'(g), 32'd3);
    step();
    check("roll_count", 32'(count_a), 32'h00);
    check("roll_wrap", 32'(wrap_a), 32'd1);
    check("roll_hex", 32'(hex_a), 32'h2040);
    step();
    check("roll_wrap_off", 32'(wrap_a), 32'd0);

    // Load 5C coinciding with a tick
    next_tick(g);
    check("tick_before_load", 32'(tick_a), 32'd1);
    do_load(8'h5C);
    check("clamp_count", 32'(count_a), 32'h59);
    check("clamp_presc", 32'(dut_a.presc_q), 32'd0);
    check("clamp_wrap", 32'(wrap_a), 32'd0);
    check("clamp_hex", 32'(hex_a), 32'h0910);
    next_tick(g);
    check("post_load_gap", 32'(g), 32'd3);
    step();
    check("step60", 32'(count_a), 32'h60);

    // en low for 3 cycles delays the tick by 3
    step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("en_hold_count", 32'(count_a), 32'h60);
      check("en_hold_tick", 32'(tick_a), 32'd0);
      check("en_hold_presc", 32'(dut_a.presc_q), 32'd1);
    end
    en = 1'b1;
    next_tick(g);
    check("en_gap", 32'(g), 32'd2);
    step();
    check("step61", 32'(count_a), 32'h61);

    do_load(8'hF3);
    check("clamp_hi", 32'(count_a), 32'h93);
    check("clamp_hi_hex", 32'(hex_a), 32'h0830);

    en = 1'b0;
    do_load(8'h25);
    check("load_en0", 32'(count_a), 32'h25);
    en = 1'b1;

    // clear pulse between edges at 47
    do_load(8'h47);
    check("load47", 32'(count_a), 32'h47);
    #2 clear = 1'b0;
    #1;
    check("clr_count", 32'(count_a), 32'h00);
    check("clr_hex", 32'(hex_a), 32'h2040);
    check("clr_presc", 32'(dut_a.presc_q), 32'd0);
    #1 clear = 1'b1;
    next_tick(g);
    check("clr_gap", 32'(g), 32'd3);
    step();
    check("clr_step", 32'(count_a), 32'h01);

    // clear in the wrap cycle cancels the pulse
    do_load(8'h99);
    next_tick(g);
    step();
    check("pre_clr_wrap", 32'(wrap_a), 32'd1);
    #2 clear = 1'b0;
    #1;
    check("clr_wrap", 32'(wrap_a), 32'd0);
    #1 clear = 1'b1;
    next_tick(g);
    check("clr2_gap", 32'(g), 32'd3);
    step();
    check("clr2_step", 32'(count_a), 32'h01);
    check("clr2_wrap", 32'(wrap_a), 32'd0);

`ifdef BCD_RATE_COUNTER_DOWN_EN
    up_dn = 1'b0;
    do_load(8'h00);
    next_tick(g);
    step();
    check("down_roll", 32'(count_a), 32'h99);
    check("down_wrap", 32'(wrap_a), 32'd1);
    step();
    check("down_wrap_off", 32'(wrap_a), 32'd0);
    do_load(8'h10);
    next_tick(g);
    step();
    check("down_borrow", 32'(count_a), 32'h09);
    check("down_nowrap", 32'(wrap_a), 32'd0);
    up_dn = 1'b1;
`else
    up_dn = 1'b0;
    do_load(8'h00);
    next_tick(g);
    step();
    check("updn_ignored", 32'(count_a), 32'h01);
    up_dn = 1'b1;
`endif

    // DIV=1 single digit: step every cycle
    load_b = 1'b1;
    load_val_b = 4'hC;
    step();
    check("b_clamp", 32'(count_b), 32'h9);
    load_val_b = 4'h0;
    step();
    load_b = 1'b0;
    check("b_load0", 32'(count_b), 32'h0);
    check("b_load_nowrap", 32'(wrap_b), 32'd0);
    for (int k = 1; k <= 11; k++) begin
      step();
      check("b_count", 32'(count_b), 32'(k % 10));
      check("b_wrap", 32'(wrap_b), 32'((k % 10) == 0));
      check("b_tick", 32'(tick_b), 32'd1);
    end
    check("b_hex", 32'(hex_b), 32'h79);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_rate_counter.md
BCD_RATE_COUNTER -- requirements
Module: bcd_rate_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (range 1..8).
REQ-002 The block SHALL have parameter DIV, default 50000000, giving the clock cycles per count step (range 1..2^26).
REQ-003 The block SHALL have port clk, input, width 1: the single system clock, rising-edge active.
REQ-004 The block SHALL have port clear, input, width 1: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, width 1: count enable; low freezes the prescaler and digits.
REQ-006 The block SHALL have port load, input, width 1: synchronous load strobe.
REQ-007 The block SHALL have port load_val, input, width 4*DIGITS: BCD load value, digit 0 in bits [3:0].
REQ-008 The block SHALL have port up_dn, input, width 1: direction, 1 = up, 0 = down.
REQ-009 The block SHALL have port count, output, width 4*DIGITS: current BCD value, registered.
REQ-010 The block SHALL have port tick, output, width 1: step strobe, combinational.
REQ-011 The block SHALL have port wrap, output, width 1: registered one-cycle rollover pulse.
REQ-012 The block SHALL have port hex, output, width 7*DIGITS: active-low seven-segment outputs, digit i in bits [7i+6:7i], bit order a..g = bit 0..6.

Function
REQ-013 The prescaler SHALL be ceil(log2(DIV)) bits wide (minimum 1) and SHALL count 0..DIV-1 while en=1, wrapping to 0.
REQ-014 tick SHALL equal en AND (prescaler == DIV-1); with DIV=1, tick SHALL equal en.
REQ-015 On a clock edge with tick=1 and load=0, count SHALL advance one BCD step in the direction given by up_dn.
REQ-016 An up step SHALL increment digit 0 and ripple a carry so that each digit goes 9 -> 0 and increments the next digit, with no digit ever holding 10..15.
REQ-017 A down step SHALL decrement with borrow, each digit going 0 -> 9.
REQ-018 An up step from all-9 SHALL produce all-0; a down step from all-0 SHALL produce all-9; in both cases wrap SHALL be 1 for exactly the following cycle.
REQ-019 wrap SHALL be 0 in every other cycle.
REQ-020 When load=1, at the clock edge count SHALL take load_val with every digit greater than 9 clamped to 9, and the prescaler SHALL go to 0.
REQ-021 load SHALL override a simultaneous tick, SHALL suppress wrap, and SHALL act regardless of en.
REQ-022 When en=0 and load=0, the prescaler and count SHALL hold.
REQ-023 A change of up_dn SHALL take effect on the next tick, with the prescaler phase undisturbed.
REQ-024 Each hex digit SHALL be a combinational decode of its count digit: 0..9 as standard, a = bit 0, segment low = lit.

Reset
REQ-025 While clear=0, the prescaler, count and wrap SHALL be 0 asynchronously, and hex SHALL show "0" on every digit (7'b1000000).
REQ-026 Deassertion of clear SHALL take effect on the next rising clk edge, with the first tick occurring DIV enabled cycles later.
REQ-027 Assertion of clear mid-count or in the cycle of a wrap SHALL cancel any pending wrap pulse.

Configuration
REQ-028 With macro BCD_RATE_COUNTER_DOWN_EN defined, up_dn SHALL be functional as specified.
REQ-029 Without BCD_RATE_COUNTER_DOWN_EN, the block SHALL count up only, up_dn SHALL be ignored, and no borrow logic SHALL be synthesised.

Verification
REQ-030 DIGITS=2, DIV=4, en=1, up: the bench SHALL check tick every 4th cycle, count 00 -> 01 -> ... -> 09 -> 10, and 99 -> 00 with wrap high for exactly one cycle.
REQ-031 DOWN_EN defined, up_dn=0, starting from 00: the bench SHALL check that the next tick gives 99, wrap pulses once, and 10 -> 09.
REQ-032 load_val=8'h5C with load=1 coinciding with a tick: the bench SHALL check count=59, prescaler=0, and wrap=0.
REQ-033 Toggling en mid-period: the bench SHALL check that en=0 for 3 cycles delays the next tick by exactly 3 cycles and that count holds.
REQ-034 clear pulsed low between clock edges at count=47: the bench SHALL check count=00 and hex=14'h2040 immediately, and the first tick 4 cycles after release.
REQ-035 DIV=1, DIGITS=1, macro undefined, up_dn=0: the bench SHALL check an increment every cycle (0..9, 0), with wrap on every 9 -> 0.
